echo_app_copy_engine: RTL and testbench

Parametrised per-flow copy controller for the echo application: pops an active flow ID, reads that flow's RX (head, commit) and TX (head, tail) ring pointers, and computes a bounded copy length. It then issues one copy command to the payload mover, waits for completion, writes back the advanced RX head and TX tail, and requeues the flow. It sits between the active-flow FIFO, the RX/TX pointer memories and the payload copy unit. Unlike the previous fixed controller, it carries its own pointer arithmetic, applies chunk limiting, handles wrap-around, overlaps the two pointer writes and keeps statistics counters.

---
 rtl/echo_app_copy_engine.sv | 185 ++++++++++++++++++
 tb/tb_echo_app_copy_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_app_copy_engine.sv
// Per-flow copy controller: pops a flow, reads its RX/TX ring pointers, issues one bounded copy,
// writes back the advanced pointers and requeues the flow. One flow in flight at a time.
module echo_app_copy_engine #(
  parameter int FLOWID_W  = 8,
  parameter int PTR_W     = 8,
  parameter int MAX_CHUNK = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flow_val,
  input  logic [FLOWID_W-1:0] flow_id,
  output logic                flow_yumi,
  output logic                rx_rd_req_val,
  output logic [FLOWID_W-1:0] rx_rd_req_flowid,
  input  logic                rx_rd_req_rdy,
  input  logic                rx_rd_resp_val,
  input  logic [PTR_W-1:0]    rx_rd_resp_head,
  input  logic [PTR_W-1:0]    rx_rd_resp_commit,
  output logic                rx_rd_resp_rdy,
  output logic                tx_rd_req_val,
  output logic [FLOWID_W-1:0] tx_rd_req_flowid,
  input  logic                tx_rd_req_rdy,
  input  logic                tx_rd_resp_val,
  input  logic [PTR_W-1:0]    tx_rd_resp_head,
  input  logic [PTR_W-1:0]    tx_rd_resp_tail,
  output logic                tx_rd_resp_rdy,
  output logic                copy_req_val,
  output logic [FLOWID_W-1:0] copy_req_flowid,
  output logic [PTR_W-2:0]    copy_req_src_off,
  output logic [PTR_W-2:0]    copy_req_dst_off,
  output logic [PTR_W-1:0]    copy_req_len,
  input  logic                copy_req_rdy,
  input  logic                copy_done_val,
  output logic                copy_done_rdy,
  output logic                rx_head_wr_val,
  output logic [FLOWID_W-1:0] rx_head_wr_flowid,
  output logic [PTR_W-1:0]    rx_head_wr_ptr,
  input  logic                rx_head_wr_rdy,
  output logic                tx_tail_wr_val,
  output logic [FLOWID_W-1:0] tx_tail_wr_flowid,
  output logic [PTR_W-1:0]    tx_tail_wr_ptr,
  input  logic                tx_tail_wr_rdy,
  output logic                requeue_val,
  output logic [FLOWID_W-1:0] requeue_flowid,
  input  logic                requeue_rdy,
  output logic [31:0]         stat_bytes,
  output logic [31:0]         stat_flows,
  output logic                busy
);

  localparam logic [PTR_W:0] BUF_SZ = (PTR_W+1)'(1) << (PTR_W-1);
  localparam logic [PTR_W:0] CHUNK  = (PTR_W+1)'(MAX_CHUNK);

  typedef enum logic [3:0] {
    IDLE, RX_REQ, RX_RESP, TX_REQ, TX_RESP, CALC, COPY_REQ, COPY_WAIT, PTR_WR, REQUEUE
  } state_t;

  state_t state, state_nx;

  logic [FLOWID_W-1:0] fid;
  logic [PTR_W-1:0]    rx_head, rx_commit, tx_head, tx_tail, len;
  logic                rx_wr_done, tx_wr_done;

  // Occupancy arithmetic wraps mod 2^PTR_W; anything above BUF means corrupt pointers.
  logic [PTR_W-1:0] rx_avail, tx_used;
  logic [PTR_W:0]   tx_space, calc_len;

  assign rx_avail = rx_commit - rx_head;
  assign tx_used  = tx_tail - tx_head;
  assign tx_space = BUF_SZ - {1'b0, tx_used};

  always_comb begin
    calc_len = {1'b0, rx_avail};
    if (tx_space < calc_len) calc_len = tx_space;
    if (CHUNK < calc_len)    calc_len = CHUNK;
    if ({1'b0, rx_avail} > BUF_SZ || {1'b0, tx_used} > BUF_SZ) calc_len = '0;
  end

  always_comb begin
    state_nx       = state;
    flow_yumi      = 1'b0;
    rx_rd_req_val  = 1'b0;
    rx_rd_resp_rdy = 1'b0;
    tx_rd_req_val  = 1'b0;
    tx_rd_resp_rdy = 1'b0;
    copy_req_val   = 1'b0;
    copy_done_rdy  = 1'b0;
    rx_head_wr_val = 1'b0;
    tx_tail_wr_val = 1'b0;
    requeue_val    = 1'b0;
    case (state)
      IDLE: begin
        flow_yumi = flow_val;
        if (flow_val) state_nx = RX_REQ;
      end
      RX_REQ: begin
        rx_rd_req_val = 1'b1;
        if (rx_rd_req_rdy) state_nx = RX_RESP;
      end
      RX_RESP: begin
        rx_rd_resp_rdy = 1'b1;
        if (rx_rd_resp_val) state_nx = TX_REQ;
      end
      TX_REQ: begin
        tx_rd_req_val = 1'b1;
        if (tx_rd_req_rdy) state_nx = TX_RESP;
      end
      TX_RESP: begin
        tx_rd_resp_rdy = 1'b1;
        if (tx_rd_resp_val) state_nx = CALC;
      end
      CALC: state_nx = (calc_len == '0) ? REQUEUE : COPY_REQ;
      COPY_REQ: begin
        copy_req_val = 1'b1;
        if (copy_req_rdy) state_nx = COPY_WAIT;
      end
      COPY_WAIT: begin
        copy_done_rdy = 1'b1;
        if (copy_done_val) state_nx = PTR_WR;
      end
      PTR_WR: begin
        // Each write retires independently; leave once both have been accepted.
        rx_head_wr_val = !rx_wr_done;
        tx_tail_wr_val = !tx_wr_done;
        if ((rx_wr_done || rx_head_wr_rdy) && (tx_wr_done || tx_tail_wr_rdy)) state_nx = REQUEUE;
      end
      REQUEUE: begin
        requeue_val = 1'b1;
        if (requeue_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fid        <= '0;
      rx_head    <= '0;
      rx_commit  <= '0;
      tx_head    <= '0;
      tx_tail    <= '0;
      len        <= '0;
      rx_wr_done <= 1'b0;
      tx_wr_done <= 1'b0;
      stat_bytes <= '0;
      stat_flows <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && flow_val) fid <= flow_id;
      if (state == RX_RESP && rx_rd_resp_val) begin
        rx_head   <= rx_rd_resp_head;
        rx_commit <= rx_rd_resp_commit;
      end
      if (state == TX_RESP && tx_rd_resp_val) begin
        tx_head <= tx_rd_resp_head;
        tx_tail <= tx_rd_resp_tail;
      end
      if (state == CALC) len <= calc_len[PTR_W-1:0];
      if (state == COPY_WAIT && copy_done_val) stat_bytes <= stat_bytes + 32'(len);
      if (state == PTR_WR && state_nx == PTR_WR) begin
        rx_wr_done <= rx_wr_done | rx_head_wr_rdy;
        tx_wr_done <= tx_wr_done | tx_tail_wr_rdy;
      end else begin
        rx_wr_done <= 1'b0;
        tx_wr_done <= 1'b0;
      end
      if (state == REQUEUE && requeue_rdy) stat_flows <= stat_flows + 32'd1;
    end
  end

  assign rx_rd_req_flowid  = fid;
  assign tx_rd_req_flowid  = fid;
  assign copy_req_flowid   = fid;
  assign copy_req_src_off  = rx_head[PTR_W-2:0];
  assign copy_req_dst_off  = tx_tail[PTR_W-2:0];
  assign copy_req_len      = len;
  assign rx_head_wr_flowid = fid;
  assign rx_head_wr_ptr    = rx_head + len;
  assign tx_tail_wr_flowid = fid;
  assign tx_tail_wr_ptr    = tx_tail + len;
  assign requeue_flowid    = fid;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_echo_app_copy_engine.sv
// Scoreboard bench for echo_app_copy_engine: a driver plays FIFO, pointer memories and mover;
// a monitor pops expected transactions computed from ring arithmetic at pop time.
module tb_echo_app_copy_engine;
  localparam int FW = 8;
  localparam int PW = 8;
  localparam int RING = 1 << PW;
  localparam int BUFB = 1 << (PW - 1);
  localparam int CHUNK = 64;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic          flow_val = 0, flow_yumi;
  logic [FW-1:0] flow_id = 0;
  logic          rx_rd_req_val, rx_rd_req_rdy = 0;
  logic [FW-1:0] rx_rd_req_flowid;
  logic          rx_rd_resp_val = 0, rx_rd_resp_rdy;
  logic [PW-1:0] rx_rd_resp_head = 0, rx_rd_resp_commit = 0;
  logic          tx_rd_req_val, tx_rd_req_rdy = 0;
  logic [FW-1:0] tx_rd_req_flowid;
  logic          tx_rd_resp_val = 0, tx_rd_resp_rdy;
  logic [PW-1:0] tx_rd_resp_head = 0, tx_rd_resp_tail = 0;
  logic          copy_req_val, copy_req_rdy = 0;
  logic [FW-1:0] copy_req_flowid;
  logic [PW-2:0] copy_req_src_off, copy_req_dst_off;
  logic [PW-1:0] copy_req_len;
  logic          copy_done_val = 0, copy_done_rdy;
  logic          rx_head_wr_val, rx_head_wr_rdy = 0;
  logic [FW-1:0] rx_head_wr_flowid;
  logic [PW-1:0] rx_head_wr_ptr;
  logic          tx_tail_wr_val, tx_tail_wr_rdy = 0;
  logic [FW-1:0] tx_tail_wr_flowid;
  logic [PW-1:0] tx_tail_wr_ptr;
  logic          requeue_val, requeue_rdy = 0;
  logic [FW-1:0] requeue_flowid;
  logic [31:0]   stat_bytes, stat_flows;
  logic          busy;

  echo_app_copy_engine #(.FLOWID_W(FW), .PTR_W(PW), .MAX_CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .flow_val(flow_val), .flow_id(flow_id), .flow_yumi(flow_yumi),
    .rx_rd_req_val(rx_rd_req_val), .rx_rd_req_flowid(rx_rd_req_flowid), .rx_rd_req_rdy(rx_rd_req_rdy),
    .rx_rd_resp_val(rx_rd_resp_val), .rx_rd_resp_head(rx_rd_resp_head),
    .rx_rd_resp_commit(rx_rd_resp_commit), .rx_rd_resp_rdy(rx_rd_resp_rdy),
    .tx_rd_req_val(tx_rd_req_val), .tx_rd_req_flowid(tx_rd_req_flowid), .tx_rd_req_rdy(tx_rd_req_rdy),
    .tx_rd_resp_val(tx_rd_resp_val), .tx_rd_resp_head(tx_rd_resp_head),
    .tx_rd_resp_tail(tx_rd_resp_tail), .tx_rd_resp_rdy(tx_rd_resp_rdy),
    .copy_req_val(copy_req_val), .copy_req_flowid(copy_req_flowid),
    .copy_req_src_off(copy_req_src_off), .copy_req_dst_off(copy_req_dst_off),
    .copy_req_len(copy_req_len), .copy_req_rdy(copy_req_rdy),
    .copy_done_val(copy_done_val), .copy_done_rdy(copy_done_rdy),
    .rx_head_wr_val(rx_head_wr_val), .rx_head_wr_flowid(rx_head_wr_flowid),
    .rx_head_wr_ptr(rx_head_wr_ptr), .rx_head_wr_rdy(rx_head_wr_rdy),
    .tx_tail_wr_val(tx_tail_wr_val), .tx_tail_wr_flowid(tx_tail_wr_flowid),
    .tx_tail_wr_ptr(tx_tail_wr_ptr), .tx_tail_wr_rdy(tx_tail_wr_rdy),
    .requeue_val(requeue_val), .requeue_flowid(requeue_flowid), .requeue_rdy(requeue_rdy),
    .stat_bytes(stat_bytes), .stat_flows(stat_flows), .busy(busy)
  );

  typedef struct packed {
    logic [FW-1:0] fid;
    logic [PW-2:0] src;
    logic [PW-2:0] dst;
    logic [PW-1:0] len;
  } copy_t;

  int checks = 0, failures = 0;

  // environment / model state
  logic [PW-1:0] mem_rxh[256], mem_rxc[256], mem_txh[256], mem_txt[256];
  logic [FW-1:0] fifo[$];
  copy_t         exp_copy[$];
  logic [FW+PW-1:0] exp_rxwr[$], exp_txwr[$];
  logic [FW-1:0] exp_rq[$];
  longint        exp_bytes = 0, exp_flows = 0;
  logic          stall = 0, rand_mem = 0, hold_done = 0;
  logic          rx_pend = 0, tx_pend = 0, done_pend = 0;
  logic [FW-1:0] rx_pend_id = 0, tx_pend_id = 0, cur_id = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int model_len(int rh, int rc, int th, int tt);
    int avail, used, l;
    avail = (rc - rh + RING) % RING;
    used  = (tt - th + RING) % RING;
    if (avail > BUFB || used > BUFB) return 0;
    l = avail;
    if (BUFB - used < l) l = BUFB - used;
    if (CHUNK < l) l = CHUNK;
    return l;
  endfunction

  function automatic bit coin();
    return !stall || ($urandom_range(0, 2) != 0);
  endfunction

  // driver: all inputs change on the falling edge
  initial begin
    logic [2:0] skew;
    logic r;
    skew = '1;
    forever begin
      @(negedge clk);
      flow_val = (fifo.size() > 0) && coin();
      flow_id  = (fifo.size() > 0) ? fifo[0] : FW'($urandom);
      rx_rd_req_rdy     = coin();
      rx_rd_resp_val    = rx_pend && coin();
      rx_rd_resp_head   = rx_rd_resp_val ? mem_rxh[rx_pend_id] : PW'($urandom);
      rx_rd_resp_commit = rx_rd_resp_val ? mem_rxc[rx_pend_id] : PW'($urandom);
      tx_rd_req_rdy     = coin();
      tx_rd_resp_val    = tx_pend && coin();
      tx_rd_resp_head   = tx_rd_resp_val ? mem_txh[tx_pend_id] : PW'($urandom);
      tx_rd_resp_tail   = tx_rd_resp_val ? mem_txt[tx_pend_id] : PW'($urandom);
      copy_req_rdy      = coin();
      copy_done_val     = done_pend && !hold_done && coin();
      r = coin();
      tx_tail_wr_rdy = r;
      rx_head_wr_rdy = skew[2];
      skew = {skew[1:0], r};
      requeue_rdy = coin();
    end
  end

  // monitor: observes handshakes that will fire at the next rising edge
  initial begin
    logic p_cv, p_cf, p_rv, p_rf, p_tv, p_tf, p_qv, p_qf;
    copy_t p_c;
    logic [FW+PW-1:0] p_r, p_t, w;
    logic [FW-1:0] p_q;
    copy_t c, e;
    logic fpop, frq, frs, ftq, fts, fc, fd, frw, ftw, fq;
    int l;
    p_cv = 0; p_cf = 0; p_rv = 0; p_rf = 0; p_tv = 0; p_tf = 0; p_qv = 0; p_qf = 0;
    p_c = '0; p_r = '0; p_t = '0; p_q = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_cv = 0; p_rv = 0; p_tv = 0; p_qv = 0;
        continue;
      end
      fpop = flow_val && flow_yumi;
      frq = rx_rd_req_val && rx_rd_req_rdy;
      frs = rx_rd_resp_val && rx_rd_resp_rdy;
      ftq = tx_rd_req_val && tx_rd_req_rdy;
      fts = tx_rd_resp_val && tx_rd_resp_rdy;
      fc  = copy_req_val && copy_req_rdy;
      fd  = copy_done_val && copy_done_rdy;
      frw = rx_head_wr_val && rx_head_wr_rdy;
      ftw = tx_tail_wr_val && tx_tail_wr_rdy;
      fq  = requeue_val && requeue_rdy;
      c = '{fid: copy_req_flowid, src: copy_req_src_off, dst: copy_req_dst_off, len: copy_req_len};

      // held requests must stay valid and unchanged
      if (p_cv && !p_cf) begin chk("copy_hold_val", copy_req_val, 1); chk("copy_hold_fields", c, p_c); end
      if (p_rv && !p_rf) begin chk("rxwr_hold_val", rx_head_wr_val, 1); chk("rxwr_hold_fields", {rx_head_wr_flowid, rx_head_wr_ptr}, p_r); end
      if (p_tv && !p_tf) begin chk("txwr_hold_val", tx_tail_wr_val, 1); chk("txwr_hold_fields", {tx_tail_wr_flowid, tx_tail_wr_ptr}, p_t); end
      if (p_qv && !p_qf) begin chk("rq_hold_val", requeue_val, 1); chk("rq_hold_fields", requeue_flowid, p_q); end
      if (rx_rd_resp_rdy) chk("rx_resp_rdy_only_when_pending", rx_pend, 1);
      if (tx_rd_resp_rdy) chk("tx_resp_rdy_only_when_pending", tx_pend, 1);

      if (fpop) begin
        chk("pop_fifo_head", flow_id, fifo[0]);
        void'(fifo.pop_front());
        cur_id = flow_id;
        if (rand_mem) begin
          mem_rxh[flow_id] = PW'($urandom);
          mem_rxc[flow_id] = mem_rxh[flow_id] + PW'($urandom_range(0, 140));
          mem_txh[flow_id] = PW'($urandom);
          mem_txt[flow_id] = mem_txh[flow_id] + PW'($urandom_range(0, 132));
        end
        l = model_len(mem_rxh[flow_id], mem_rxc[flow_id], mem_txh[flow_id], mem_txt[flow_id]);
        if (l > 0) begin
          e.fid = flow_id;
          e.src = PW'((int'(mem_rxh[flow_id]) % BUFB));
          e.dst = PW'((int'(mem_txt[flow_id]) % BUFB));
          e.len = PW'(l);
          exp_copy.push_back(e);
          exp_rxwr.push_back({flow_id, PW'((int'(mem_rxh[flow_id]) + l) % RING)});
          exp_txwr.push_back({flow_id, PW'((int'(mem_txt[flow_id]) + l) % RING)});
          exp_bytes += l;
        end
        exp_rq.push_back(flow_id);
      end
      if (frq) begin chk("rx_rd_flowid", rx_rd_req_flowid, cur_id); rx_pend = 1; rx_pend_id = rx_rd_req_flowid; end
      if (frs) rx_pend = 0;
      if (ftq) begin chk("tx_rd_flowid", tx_rd_req_flowid, cur_id); tx_pend = 1; tx_pend_id = tx_rd_req_flowid; end
      if (fts) tx_pend = 0;
      if (fc) begin
        if (exp_copy.size() == 0) chk("copy_unexpected", 1, 0);
        else chk("copy_req", c, exp_copy.pop_front());
        done_pend = 1;
      end
      if (fd) done_pend = 0;
      if (frw) begin
        w = {rx_head_wr_flowid, rx_head_wr_ptr};
        if (exp_rxwr.size() == 0) chk("rxwr_unexpected", 1, 0);
        else chk("rx_head_wr", w, exp_rxwr.pop_front());
        mem_rxh[rx_head_wr_flowid] = rx_head_wr_ptr;
      end
      if (ftw) begin
        w = {tx_tail_wr_flowid, tx_tail_wr_ptr};
        if (exp_txwr.size() == 0) chk("txwr_unexpected", 1, 0);
        else chk("tx_tail_wr", w, exp_txwr.pop_front());
        mem_txt[tx_tail_wr_flowid] = tx_tail_wr_ptr;
      end
      if (fq) begin
        if (exp_rq.size() == 0) chk("rq_unexpected", 1, 0);
        else chk("requeue", requeue_flowid, exp_rq.pop_front());
        exp_flows++;
      end

      p_cv = copy_req_val; p_cf = fc; p_c = c;
      p_rv = rx_head_wr_val; p_rf = frw; p_r = {rx_head_wr_flowid, rx_head_wr_ptr};
      p_tv = tx_tail_wr_val; p_tf = ftw; p_t = {tx_tail_wr_flowid, tx_tail_wr_ptr};
      p_qv = requeue_val; p_qf = fq; p_q = requeue_flowid;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fifo.size() > 0 || exp_rq.size() > 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("idle_within_budget", (n < budget), 1);
  endtask

  task automatic run_flow(input int id, input int rh, input int rc, input int th, input int tt);
    mem_rxh[id] = PW'(rh); mem_rxc[id] = PW'(rc);
    mem_txh[id] = PW'(th); mem_txt[id] = PW'(tt);
    fifo.push_back(FW'(id));
    wait_idle(500);
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_bytes"}, stat_bytes, 64'(exp_bytes[31:0]));
    chk({name, "_flows"}, stat_flows, 64'(exp_flows[31:0]));
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_vals"}, {flow_yumi, rx_rd_req_val, rx_rd_resp_rdy, tx_rd_req_val, tx_rd_resp_rdy,
                          copy_req_val, copy_done_rdy, rx_head_wr_val, tx_tail_wr_val, requeue_val}, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_stat_bytes"}, stat_bytes, 0);
    chk({name, "_stat_flows"}, stat_flows, 0);
  endtask

  initial begin
    int n;
    rst = 1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_data", {copy_req_len, rx_head_wr_ptr, tx_tail_wr_ptr, requeue_flowid}, 0);
    rst = 0;

    run_flow(3, 0, 40, 0, 0);
    chk_stats("basic");
    chk("basic_bytes_const", stat_bytes, 40);
    run_flow(4, 0, 100, 0, 0);
    chk("chunk_bytes_const", stat_bytes, 104);
    run_flow(5, 0, 20, 0, 128);
    run_flow(6, 5, 5, 0, 128);
    chk("txfull_bytes_const", stat_bytes, 104);
    chk("txfull_flows_const", stat_flows, 4);
    run_flow(9, 250, 10, 0, 120);
    chk("wrap_bytes_const", stat_bytes, 112);
    chk_stats("directed");

    stall = 1; rand_mem = 1;
    for (int i = 0; i < 60; i++) fifo.push_back(FW'($urandom_range(0, 15)));
    wait_idle(20000);
    chk_stats("random");
    stall = 0; rand_mem = 0;

    hold_done = 1;
    mem_rxh[7] = 0; mem_rxc[7] = 40; mem_txh[7] = 0; mem_txt[7] = 0;
    fifo.push_back(7);
    n = 0;
    while (!done_pend && n < 200) begin @(negedge clk); n++; end
    chk("reached_copy_wait", done_pend, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_quiet("midreset");
    rst = 0;
    exp_copy.delete(); exp_rxwr.delete(); exp_txwr.delete(); exp_rq.delete(); fifo.delete();
    done_pend = 0; rx_pend = 0; tx_pend = 0; hold_done = 0;
    exp_bytes = 0; exp_flows = 0;
    run_flow(7, 0, 40, 0, 0);
    chk_stats("after_reset");
    chk("after_reset_bytes_const", stat_bytes, 40);

    chk("leftover_copy", exp_copy.size(), 0);
    chk("leftover_rxwr", exp_rxwr.size(), 0);
    chk("leftover_txwr", exp_txwr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
